control_principal_n: RTL and testbench

Parametrised successor to the front-panel command controller: conditions N_CMD momentary push-button commands plus a mode button and a master-reset button, all in one clock domain. Per input it synchronises, debounces and edge-detects, then emits single-cycle command pulses. Held buttons auto-repeat. A global enable gates all user commands. Outputs feed the frequency/duty-cycle adjustment datapath and the mode/reset logic downstream.

---
 rtl/control_principal_n.sv | 185 ++++++++++++++++++
 tb/tb_control_principal_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_principal_n.sv
// control_principal_n: front-panel command conditioner. Every raw button is synchronised,
// debounced and edge-detected; command buttons emit single-cycle pulses with hold-to-repeat.
module control_principal_n #(
   parameter int N_CMD      = 4,
   parameter int DB_CYCLES  = 4,
   parameter int REP_DELAY  = 16,
   parameter int REP_PERIOD = 4,
   parameter int MRST_LEN   = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [N_CMD-1:0] cmd_i,
   input  logic             modo_i,
   input  logic             mrst_i,
   output logic [N_CMD-1:0] cmd_o,
   output logic             modo_o,
   output logic             mrst_o
);

   localparam int N_IN   = N_CMD + 2;
   localparam int I_MODO = N_CMD;
   localparam int I_MRST = N_CMD + 1;
   localparam int DB_W   = $clog2(DB_CYCLES + 1);
   localparam int HC_W   = (REP_DELAY > 1) ? $clog2(REP_DELAY) : 1;
   localparam int MR_W   = (MRST_LEN > 1) ? $clog2(MRST_LEN) : 1;

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(REP_DELAY - 1);
   localparam logic [HC_W-1:0] PER_LAST  = HC_W'(REP_PERIOD - 1);
   localparam logic [MR_W-1:0] MR_LAST   = MR_W'(MRST_LEN - 1);

   typedef enum logic [1:0] {IDLE, HELD_WAIT, REPEAT} state_t;

   function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] v);
      return (v == {HC_W{1'b1}}) ? v : v + HC_W'(1);
   endfunction

   logic [N_IN-1:0]  w_raw;
   logic [N_IN-1:0]  r_sync1;
   logic [N_IN-1:0]  r_sync2;
   logic [N_IN-1:0]  r_lvl;
   logic [N_IN-1:0]  r_lvl_d;
   logic [DB_W-1:0]  r_db_cnt [N_IN];
   logic [N_IN-1:0]  w_rise;
   logic [N_CMD-1:0] w_conflict;

   state_t           r_state    [N_CMD];
   state_t           w_state_nx [N_CMD];
   logic [HC_W-1:0]  r_hold     [N_CMD];
   logic [HC_W-1:0]  w_hold_nx  [N_CMD];
   logic [N_CMD-1:0] w_pulse;
   logic [N_CMD-1:0] r_cmd;

   logic             r_modo;
   logic             r_mrst;
   logic [MR_W-1:0]  r_mrst_cnt;

   assign w_raw = {mrst_i, modo_i, cmd_i};

   // Input conditioning: 2-FF synchroniser followed by a stable-sample debounce counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_lvl   <= '0;
         r_lvl_d <= '0;
         for (int i = 0; i < N_IN; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_lvl_d <= r_lvl;
         for (int i = 0; i < N_IN; i++) begin
            if (r_sync2[i] != r_lvl[i]) begin
               if (r_db_cnt[i] == DB_LAST) begin
                  r_lvl[i]    <= r_sync2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_rise = r_lvl & ~r_lvl_d;

   // Opposing buttons of a pair held together cancel each other
   always_comb begin
      w_conflict = '0;
      for (int k = 0; k < N_CMD / 2; k++) begin
         w_conflict[2*k]   = r_lvl[2*k] & r_lvl[2*k+1];
         w_conflict[2*k+1] = r_lvl[2*k] & r_lvl[2*k+1];
      end
   end

   // Per-channel hold/repeat FSM: next state, hold counter and pulse request
   always_comb begin
      w_pulse = '0;
      for (int i = 0; i < N_CMD; i++) begin
         w_state_nx[i] = r_state[i];
         w_hold_nx[i]  = r_hold[i];
         if (!r_lvl[i] || !en_i || r_mrst || w_conflict[i]) begin
            w_state_nx[i] = IDLE;
            w_hold_nx[i]  = '0;
         end else begin
            case (r_state[i])
               IDLE: begin
                  if (w_rise[i]) begin
                     w_state_nx[i] = HELD_WAIT;
                     w_hold_nx[i]  = '0;
                     w_pulse[i]    = 1'b1;
                  end
               end
               HELD_WAIT: begin
                  if (r_hold[i] == HOLD_LAST) begin
                     w_state_nx[i] = REPEAT;
                     w_hold_nx[i]  = '0;
                     w_pulse[i]    = 1'b1;
                  end else begin
                     w_hold_nx[i]  = sat_inc(r_hold[i]);
                  end
               end
               REPEAT: begin
                  if (r_hold[i] == PER_LAST) begin
                     w_hold_nx[i]  = '0;
                     w_pulse[i]    = 1'b1;
                  end else begin
                     w_hold_nx[i]  = sat_inc(r_hold[i]);
                  end
               end
               default: begin
                  w_state_nx[i] = IDLE;
                  w_hold_nx[i]  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cmd <= '0;
         for (int i = 0; i < N_CMD; i++) begin
            r_state[i] <= IDLE;
            r_hold[i]  <= '0;
         end
      end else begin
         r_cmd <= w_pulse;
         for (int i = 0; i < N_CMD; i++) begin
            r_state[i] <= w_state_nx[i];
            r_hold[i]  <= w_hold_nx[i];
         end
      end
   end

   // Master reset is never gated by en_i and cannot be retriggered while running
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mrst     <= 1'b0;
         r_mrst_cnt <= '0;
         r_modo     <= 1'b0;
      end else begin
         if (r_mrst) begin
            if (r_mrst_cnt == '0) r_mrst <= 1'b0;
            else                  r_mrst_cnt <= r_mrst_cnt - MR_W'(1);
         end else if (w_rise[I_MRST]) begin
            r_mrst     <= 1'b1;
            r_mrst_cnt <= MR_LAST;
         end

         if (w_rise[I_MRST] && !r_mrst)
            r_modo <= 1'b0;
         else if (w_rise[I_MODO] && en_i && !r_mrst)
            r_modo <= ~r_modo;
      end
   end

   assign cmd_o  = r_cmd;
   assign modo_o = r_modo;
   assign mrst_o = r_mrst;

endmodule

// File: tb/tb_control_principal_n.sv
// Directed bench for control_principal_n: a vector table of press/hold scenarios plus
// hand-written multi-cycle sequences (exact repeat timing, pair conflict, enable, master reset).
module tb_control_principal_n;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i, en_i, modo_i, mrst_i;
   logic [3:0] cmd_i, cmd_o;
   logic       modo_o, mrst_o;

   logic       en6, modo6_i, mrst6_i;
   logic [5:0] cmd6_i, cmd6_o;
   logic       modo6_o, mrst6_o;

   control_principal_n u_dut (
      .clk_i (clk),   .rst_i (rst_i), .en_i  (en_i),
      .cmd_i (cmd_i), .modo_i(modo_i), .mrst_i(mrst_i),
      .cmd_o (cmd_o), .modo_o(modo_o), .mrst_o(mrst_o)
   );

   control_principal_n #(
      .N_CMD(6), .DB_CYCLES(1), .REP_DELAY(4), .REP_PERIOD(1), .MRST_LEN(2)
   ) u_dut6 (
      .clk_i (clk),    .rst_i (rst_i),   .en_i  (en6),
      .cmd_i (cmd6_i), .modo_i(modo6_i), .mrst_i(mrst6_i),
      .cmd_o (cmd6_o), .modo_o(modo6_o), .mrst_o(mrst6_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int q[$];
   int exp_q[$];

   typedef struct {
      logic        en;
      logic [3:0]  cmd;
      logic        modo;
      logic        mrst;
      int          hold;
      logic [15:0] exp_cnt;   // nibble b = expected pulse count on cmd_o[b]
      int          exp_first; // tick of first cmd pulse, 0 = none
      logic        exp_modo;
      int          exp_mrst;  // cycles with mrst_o high
   } vec_t;

   vec_t tbl [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic check_q(input string nm);
      check({nm, " count"}, q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < q.size()) check($sformatf("%s pulse %0d tick", nm, i), q[i], exp_q[i]);
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int cnt [4];
      int first, mcnt, other, m6, m7;

      tbl[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0,  3, 16'h0000, 0, 1'b0, 0}; // glitch < DB
      tbl[1]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 20, 16'h0002, 7, 1'b0, 0}; // 0,16
      tbl[2]  = '{1'b1, 4'b0010, 1'b0, 1'b0,  8, 16'h0010, 7, 1'b0, 0}; // short press
      tbl[3]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 24, 16'h0300, 7, 1'b0, 0}; // 0,16,20
      tbl[4]  = '{1'b1, 4'b1000, 1'b0, 1'b0,  4, 16'h1000, 7, 1'b0, 0}; // exactly DB
      tbl[5]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 20, 16'h0000, 0, 1'b0, 0}; // disabled
      tbl[6]  = '{1'b1, 4'b1100, 1'b0, 1'b0, 30, 16'h0000, 0, 1'b0, 0}; // pair conflict
      tbl[7]  = '{1'b1, 4'b0000, 1'b1, 1'b0,  6, 16'h0000, 0, 1'b1, 0}; // modo toggle
      tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0,  6, 16'h0000, 0, 1'b1, 0}; // modo disabled
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1,  6, 16'h0000, 0, 1'b0, 2}; // mrst clears modo
      tbl[10] = '{1'b1, 4'b0101, 1'b0, 1'b0, 17, 16'h0202, 7, 1'b0, 0}; // two pairs

      rst_i = 1'b1; en_i = 1'b1; cmd_i = '0; modo_i = 1'b0; mrst_i = 1'b0;
      en6 = 1'b1; cmd6_i = '0; modo6_i = 1'b0; mrst6_i = 1'b0;
      settle(3);
      check("reset cmd_o",  int'(cmd_o),  0);
      check("reset modo_o", int'(modo_o), 0);
      check("reset mrst_o", int'(mrst_o), 0);
      check("reset cmd6_o", int'(cmd6_o), 0);
      rst_i = 1'b0;
      settle(2);

      // Vector table
      for (int i = 0; i < 11; i++) begin
         for (int b = 0; b < 4; b++) cnt[b] = 0;
         first = 0; mcnt = 0;
         en_i = tbl[i].en; cmd_i = tbl[i].cmd; modo_i = tbl[i].modo; mrst_i = tbl[i].mrst;
         for (int k = 1; k <= tbl[i].hold + 12; k++) begin
            tick();
            for (int b = 0; b < 4; b++)
               if (cmd_o[b]) begin
                  cnt[b]++;
                  if (first == 0) first = k;
               end
            if (mrst_o) mcnt++;
            if (k == tbl[i].hold) begin
               cmd_i = '0; modo_i = 1'b0; mrst_i = 1'b0;
            end
         end
         for (int b = 0; b < 4; b++)
            check($sformatf("vec%0d cmd_o[%0d] pulses", i, b), cnt[b],
                  int'(tbl[i].exp_cnt[4*b +: 4]));
         check($sformatf("vec%0d first pulse", i), first, tbl[i].exp_first);
         check($sformatf("vec%0d modo_o", i), int'(modo_o), int'(tbl[i].exp_modo));
         check($sformatf("vec%0d mrst_o cycles", i), mcnt, tbl[i].exp_mrst);
      end

      // Long hold: exact repeat timing on cmd_o[0]
      en_i = 1'b1; cmd_i = 4'b0001; q.delete(); other = 0;
      for (int k = 1; k <= 52; k++) begin
         tick();
         if (cmd_o[0]) q.push_back(k);
         if (cmd_o[3:1] != 3'b000) other++;
         if (k == 40) cmd_i = '0;
      end
      exp_q = '{7, 23, 27, 31, 35, 39, 43};
      check_q("hold40");
      check("hold40 other bits", other, 0);

      // Pair conflict, release one, then re-press the survivor
      cnt[0] = 0;
      cmd_i = 4'b1100;
      for (int k = 0; k < 20; k++) begin tick(); if (cmd_o[3:2] != 2'b00) cnt[0]++; end
      check("conflict both held", cnt[0], 0);
      cnt[0] = 0;
      cmd_i = 4'b0100;
      for (int k = 0; k < 20; k++) begin tick(); if (cmd_o[3:2] != 2'b00) cnt[0]++; end
      check("conflict survivor held", cnt[0], 0);
      cmd_i = '0;
      settle(12);
      cnt[0] = 0; first = 0;
      cmd_i = 4'b0100;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (cmd_o[2]) begin cnt[0]++; if (first == 0) first = k; end
         if (k == 8) cmd_i = '0;
      end
      check("repress pulses", cnt[0], 1);
      check("repress first", first, 7);

      // Edges during en_i=0 are discarded even once enable returns
      en_i = 1'b0; modo_i = 1'b1; cmd_i = 4'b0010; cnt[0] = 0;
      for (int k = 0; k < 10; k++) begin tick(); if (cmd_o != 4'b0000) cnt[0]++; end
      check("disabled press pulses", cnt[0], 0);
      check("disabled press modo", int'(modo_o), 0);
      en_i = 1'b1;
      for (int k = 0; k < 20; k++) begin tick(); if (cmd_o != 4'b0000) cnt[0]++; end
      check("enable while held pulses", cnt[0], 0);
      check("enable while held modo", int'(modo_o), 0);
      modo_i = 1'b0; cmd_i = '0;
      settle(12);
      modo_i = 1'b1;
      settle(8);
      modo_i = 1'b0;
      settle(12);
      check("modo repress", int'(modo_o), 1);

      // Master reset with en_i=0 and modo_o=1
      en_i = 1'b0; mrst_i = 1'b1; q.delete(); m6 = -1; m7 = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (mrst_o) q.push_back(k);
         if (k == 6) m6 = int'(modo_o);
         if (k == 7) m7 = int'(modo_o);
         if (k == 6) mrst_i = 1'b0;
      end
      exp_q = '{7, 8};
      check_q("mrst pulse");
      check("modo before mrst", m6, 1);
      check("modo first mrst cycle", m7, 0);

      // Synchronous reset during REPEAT, button still held
      en_i = 1'b1; cmd_i = 4'b0001; q.delete();
      for (int k = 1; k <= 68; k++) begin
         tick();
         if (cmd_o[0]) q.push_back(k);
         if (k == 26) rst_i = 1'b1;
         if (k == 27) begin
            check("rst cmd_o", int'(cmd_o), 0);
            check("rst mrst_o", int'(mrst_o), 0);
            check("rst modo_o", int'(modo_o), 0);
            rst_i = 1'b0;
         end
         if (k == 56) cmd_i = '0;
      end
      exp_q = '{7, 23, 34, 50, 54, 58, 62};
      check_q("rst midhold");

      // N_CMD=6, DB=1, REP_DELAY=4, REP_PERIOD=1
      cmd6_i = 6'b100000; q.delete(); other = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (cmd6_o[5]) q.push_back(k);
         if (cmd6_o[4:0] != 5'b00000) other++;
         if (k == 12) cmd6_i = '0;
      end
      exp_q = '{4, 8, 9, 10, 11, 12, 13, 14, 15};
      check_q("n6 hold");
      check("n6 other bits", other, 0);

      // Second debounced mrst edge inside the pulse must not extend it
      mrst6_i = 1'b1; q.delete();
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (mrst6_o) q.push_back(k);
         if (k == 1) mrst6_i = 1'b0;
         if (k == 2) mrst6_i = 1'b1;
         if (k == 3) mrst6_i = 1'b0;
      end
      exp_q = '{4, 5};
      check_q("n6 mrst no extend");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
